// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
//   PS2_EXT / PS2_BRK : Set-2 extended and break prefix bytes
//   KEY_*             : Set-2 codes of the keys this block decodes
//   frame_state_e     : device-to-host frame receiver states
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises and glitch-filters the
// pins, samples data on each filtered clock fall and checks start, odd
// parity and stop. A stalled partial frame is aborted after a timeout.
//   clk, reset   : system clock, asynchronous active-high reset
//   ps2_clk/data : raw PS/2 pins
//   rx_byte      : last good data byte
//   byte_valid   : one-cycle strobe, rx_byte is new
//   byte_err     : one-cycle strobe, frame rejected (parity, stop or timeout)
//   byte_timeout : qualifies byte_err as a timeout abort
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       byte_timeout
);

    localparam int unsigned FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic              clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic              filt_q, filt_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              fall_c;
    frame_state_e      state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_ok_q, par_ok_d;
    logic [7:0]        byte_q, byte_d;
    logic              valid_q, valid_d, err_q, err_d, tmo_q, tmo_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    // Glitch filter: level flips after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall_c     = 1'b0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q;
                fall_c = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
        end
    end

    // Frame FSM next-state, checks and timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        tmo_d     = 1'b0;
        to_cnt_d  = (state_q == ST_IDLE) ? '0 : to_cnt_q + TO_W'(1);

        if (fall_c) begin
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!data_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_ok_d = ^{shift_q, data_sync_q};
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if (par_ok_q && data_sync_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign rx_byte      = byte_q;
    assign byte_valid   = valid_q;
    assign byte_err     = err_q;
    assign byte_timeout = tmo_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: decodes Set-2 scan codes into held levels for the
// arrow keys and space, plus a flap strobe on a fresh space press.
//   clk, reset          : system clock, asynchronous active-high reset
//   ps2_clk, ps2_data   : raw PS/2 pins
//   scan_code/scan_valid: last accepted byte and its one-cycle strobe
//   frame_err           : one-cycle strobe on a rejected or timed-out frame
//   key_*               : held key levels
//   flap_pulse          : one-cycle strobe on a space make while space was up
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       key_space,
    output logic       flap_pulse
);

    logic [7:0] rx_byte;
    logic       byte_valid, byte_err, byte_timeout;

    logic [7:0] scan_code_q, scan_code_d;
    logic       scan_valid_q, scan_valid_d, frame_err_q, frame_err_d;
    logic       ext_q, ext_d, brk_q, brk_d;
    logic       up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
    logic       space_q, space_d, flap_q, flap_d;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_byte      (rx_byte),
        .byte_valid   (byte_valid),
        .byte_err     (byte_err),
        .byte_timeout (byte_timeout)
    );

    // Prefix tracking and key table.
    always_comb begin
        scan_code_d  = scan_code_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        flap_d       = 1'b0;
        ext_d        = ext_q;
        brk_d        = brk_q;
        up_d         = up_q;
        down_d       = down_q;
        left_d       = left_q;
        right_d      = right_q;
        space_d      = space_q;

        if (byte_valid) begin
            scan_valid_d = 1'b1;
            scan_code_d  = rx_byte;
            if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                if (ext_q) begin
                    case (rx_byte)
                        KEY_UP:    up_d    = ~brk_q;
                        KEY_DOWN:  down_d  = ~brk_q;
                        KEY_LEFT:  left_d  = ~brk_q;
                        KEY_RIGHT: right_d = ~brk_q;
                        default:   ;
                    endcase
                end else if (rx_byte == KEY_SPACE) begin
                    space_d = ~brk_q;
                    // Typematic repeats arrive with space already held.
                    flap_d  = ~brk_q & ~space_q;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end

        if (byte_err) begin
            frame_err_d = 1'b1;
            if (byte_timeout) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_code_q  <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            space_q      <= 1'b0;
            flap_q       <= 1'b0;
        end else begin
            scan_code_q  <= scan_code_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            up_q         <= up_d;
            down_q       <= down_d;
            left_q       <= left_d;
            right_q      <= right_d;
            space_q      <= space_d;
            flap_q       <= flap_d;
        end
    end

    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign frame_err  = frame_err_q;
    assign key_up     = up_q;
    assign key_down   = down_q;
    assign key_left   = left_q;
    assign key_right  = right_q;
    assign key_space  = space_q;
    assign flap_pulse = flap_q;

endmodule
